// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one memory port between instruction fetch and data access.
// Data is preferred, but the two sides alternate when both are waiting.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic                  i_resp,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_resp,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [DATA_WIDTH-1:0] pmem_wdata,
  input  logic                  pmem_resp,
  input  logic [DATA_WIDTH-1:0] pmem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    TURN   = 2'd3
  } state_t;

  state_t                state;
  logic                  last_grant;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic                  lat_write;

  logic d_req;
  logic grant_d;
  logic busy;

  assign d_req   = d_read | d_write;
  // Data wins unless the instruction side is also waiting and data had the last turn.
  assign grant_d = d_req & (~i_read | ~last_grant);
  assign busy    = (state == I_BUSY) || (state == D_BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_write  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state      <= D_BUSY;
            last_grant <= 1'b1;
            lat_addr   <= d_address;
            lat_wdata  <= d_wdata;
            lat_write  <= d_write;
          end else if (i_read) begin
            state      <= I_BUSY;
            last_grant <= 1'b0;
            lat_addr   <= i_address;
            lat_wdata  <= '0;
            lat_write  <= 1'b0;
          end
        end
        I_BUSY, D_BUSY: begin
          if (pmem_resp) state <= TURN;
        end
        // One dead cycle so the owner can drop its request before the next sample.
        TURN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    i_rdata      = '0;
    d_rdata      = '0;
    if (busy) begin
      pmem_address = lat_addr;
      pmem_wdata   = lat_wdata;
    end
    if (state == I_BUSY) begin
      pmem_read = 1'b1;
      if (pmem_resp) begin
        i_resp  = 1'b1;
        i_rdata = pmem_rdata;
      end
    end
    if (state == D_BUSY) begin
      pmem_write = lat_write;
      pmem_read  = ~lat_write;
      if (pmem_resp) begin
        d_resp  = 1'b1;
        d_rdata = pmem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single fetch, write, fairness, latch isolation,
// reset mid-transaction, read+write collision and stray responses.
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read;
  logic [AW-1:0] i_address;
  logic          i_resp;
  logic [DW-1:0] i_rdata;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_address;
  logic [DW-1:0] d_wdata;
  logic          d_resp;
  logic [DW-1:0] d_rdata;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [DW-1:0] pmem_wdata;
  logic          pmem_resp;
  logic [DW-1:0] pmem_rdata;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_strobes(input string tag, input logic rd, input logic wr,
                             input logic [AW-1:0] addr);
    chk({tag, ".read"},  DW'(pmem_read),    DW'(rd));
    chk({tag, ".write"}, DW'(pmem_write),   DW'(wr));
    chk({tag, ".addr"},  DW'(pmem_address), DW'(addr));
  endtask

  logic [AW-1:0] exp_addr;
  logic          exp_d;

  initial begin
    rst = 1'b1; i_read = 0; i_address = '0; d_read = 0; d_write = 0;
    d_address = '0; d_wdata = '0; pmem_resp = 0; pmem_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    chk_strobes("reset", 0, 0, 16'h0000);
    chk("reset.wdata", pmem_wdata, '0);
    chk("reset.i_resp", DW'(i_resp), 0);
    chk("reset.d_resp", DW'(d_resp), 0);

    // Single instruction fetch, response after 3 busy cycles
    i_read = 1; i_address = 16'h0040;
    tick();
    chk_strobes("ifetch.c1", 1, 0, 16'h0040);
    chk("ifetch.c1.i_resp", DW'(i_resp), 0);
    tick();
    chk_strobes("ifetch.c2", 1, 0, 16'h0040);
    tick();
    pmem_resp = 1; pmem_rdata = 128'hA5;
    #1;
    chk_strobes("ifetch.c3", 1, 0, 16'h0040);
    chk("ifetch.i_resp", DW'(i_resp), 1);
    chk("ifetch.i_rdata", i_rdata, 128'hA5);
    chk("ifetch.d_resp", DW'(d_resp), 0);
    chk("ifetch.d_rdata", d_rdata, '0);
    tick();
    i_read = 0;
    #1;
    chk_strobes("ifetch.turn", 0, 0, 16'h0000);
    chk("ifetch.turn.i_resp", DW'(i_resp), 0);
    pmem_resp = 0;
    tick();
    chk_strobes("ifetch.idle", 0, 0, 16'h0000);

    // Data write
    d_write = 1; d_address = 16'h1000; d_wdata = 128'hBEEF;
    tick();
    chk_strobes("dwrite.c1", 0, 1, 16'h1000);
    chk("dwrite.c1.wdata", pmem_wdata, 128'hBEEF);
    tick();
    chk("dwrite.c2.wdata", pmem_wdata, 128'hBEEF);
    chk("dwrite.c2.d_resp", DW'(d_resp), 0);
    pmem_resp = 1; pmem_rdata = 128'h77;
    #1;
    chk("dwrite.d_resp", DW'(d_resp), 1);
    chk("dwrite.d_rdata", d_rdata, 128'h77);
    chk("dwrite.i_resp", DW'(i_resp), 0);
    tick();
    pmem_resp = 0; d_write = 0;
    #1;
    chk_strobes("dwrite.turn", 0, 0, 16'h0000);
    tick();

    // Fairness: reset, then both sides held continuously
    rst = 1; tick(); rst = 0;
    i_read = 1; i_address = 16'h0100;
    d_read = 1; d_address = 16'h0200;
    for (int k = 0; k < 4; k++) begin
      exp_d    = (k % 2 == 0);
      exp_addr = exp_d ? 16'h0200 : 16'h0100;
      tick();
      chk_strobes($sformatf("fair%0d", k), 1, 0, exp_addr);
      pmem_resp = 1; pmem_rdata = 128'(k + 1);
      #1;
      chk($sformatf("fair%0d.d_resp", k), DW'(d_resp), DW'(exp_d));
      chk($sformatf("fair%0d.i_resp", k), DW'(i_resp), DW'(!exp_d));
      tick();
      pmem_resp = 0;
      #1;
      chk($sformatf("fair%0d.turn", k), DW'(pmem_read), 0);
      tick();
    end
    i_read = 0; d_read = 0;
    tick();

    // Latch isolation: last grant was I, so data wins and its latches hold
    d_read = 1; d_address = 16'h1000;
    tick();
    chk_strobes("iso.c1", 1, 0, 16'h1000);
    d_address = 16'h2000; i_read = 1; i_address = 16'h0300;
    tick();
    chk_strobes("iso.c2", 1, 0, 16'h1000);
    pmem_resp = 1; pmem_rdata = 128'h55;
    #1;
    chk("iso.d_resp", DW'(d_resp), 1);
    chk("iso.i_resp", DW'(i_resp), 0);
    tick();
    pmem_resp = 0; d_read = 0;
    #1;
    chk_strobes("iso.turn", 0, 0, 16'h0000);
    tick();
    chk_strobes("iso.idle", 0, 0, 16'h0000);
    tick();
    chk_strobes("iso.igrant", 1, 0, 16'h0300);
    pmem_resp = 1;
    #1;
    chk("iso.i_resp2", DW'(i_resp), 1);
    tick();
    pmem_resp = 0; i_read = 0;
    tick();

    // Reset mid-transaction
    i_read = 1; i_address = 16'h0400;
    tick();
    chk_strobes("rstmid.busy", 1, 0, 16'h0400);
    rst = 1;
    tick();
    rst = 0; i_read = 0;
    #1;
    chk_strobes("rstmid.after", 0, 0, 16'h0000);
    pmem_resp = 1; pmem_rdata = 128'h99;
    #1;
    chk("rstmid.i_resp", DW'(i_resp), 0);
    chk("rstmid.i_rdata", i_rdata, '0);
    tick();
    pmem_resp = 0;
    #1;
    chk_strobes("rstmid.idle", 0, 0, 16'h0000);
    i_read = 1; i_address = 16'h0500;
    tick();
    chk_strobes("rstmid.next", 1, 0, 16'h0500);
    pmem_resp = 1; pmem_rdata = 128'h42;
    #1;
    chk("rstmid.next.i_rdata", i_rdata, 128'h42);
    tick();
    pmem_resp = 0; i_read = 0;
    tick();

    // Read and write together are treated as a write
    d_read = 1; d_write = 1; d_address = 16'h0600; d_wdata = 128'h1234;
    tick();
    chk_strobes("rw", 0, 1, 16'h0600);
    chk("rw.wdata", pmem_wdata, 128'h1234);
    pmem_resp = 1;
    #1;
    chk("rw.d_resp", DW'(d_resp), 1);
    tick();
    pmem_resp = 0; d_read = 0; d_write = 0;
    tick();

    // Stray response in IDLE
    pmem_resp = 1; pmem_rdata = 128'hFF;
    #1;
    chk("stray.i_resp", DW'(i_resp), 0);
    chk("stray.d_resp", DW'(d_resp), 0);
    chk("stray.d_rdata", d_rdata, '0);
    tick();
    pmem_resp = 0;
    #1;
    chk_strobes("stray.after", 0, 0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
